// File: rtl/sram_fifo_ctrl.sv
`timescale 1ns/1ps
// sram_fifo_ctrl: valid/ready FIFO around a 1W/1R SRAM macro, with a 4-entry output buffer
// that hides the macro's read latency. Define SRAM_FIFO_PEAK_EN to add the `peak` output.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  mem_csb0,
    output logic [ADDR_WIDTH-1:0] mem_addr0,
    output logic [DATA_WIDTH-1:0] mem_din0,
    output logic                  mem_csb1,
    output logic [ADDR_WIDTH-1:0] mem_addr1,
    input  logic [DATA_WIDTH-1:0] mem_dout1
`ifdef SRAM_FIFO_PEAK_EN
    ,
    output logic [ADDR_WIDTH:0]   peak
`endif
);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(RAM_DEPTH);

    logic [ADDR_WIDTH:0]   r_count, r_avail, w_count_next, w_avail_eff;
    logic [ADDR_WIDTH-1:0] r_wptr, r_rptr, r_addr0, r_addr1;
    logic [DATA_WIDTH-1:0] r_din0;
    logic                  r_csb0, r_csb1, r_if0, r_if1;
    logic [DATA_WIDTH-1:0] r_buf [4];
    logic [1:0]            r_head, r_tail;
    logic [2:0]            r_buf_cnt, w_occ;
    logic                  w_push, w_pop, w_issue;

    assign in_ready  = !rst && (r_count < DEPTH_C);
    assign w_push    = in_valid && in_ready;
    assign out_valid = (r_buf_cnt != 3'd0);
    assign w_pop     = out_valid && out_ready;
    assign out_data  = r_buf[r_head];
    assign count     = r_count;
    assign mem_csb0  = r_csb0;
    assign mem_addr0 = r_addr0;
    assign mem_din0  = r_din0;
    assign mem_csb1  = r_csb1;
    assign mem_addr1 = r_addr1;

    // A write being sampled by the macro on this edge may be read-issued now: its read is sampled one edge later.
    assign w_avail_eff  = r_avail + {{ADDR_WIDTH{1'b0}}, !r_csb0};
    assign w_occ        = r_buf_cnt + {2'b00, r_if0} + {2'b00, r_if1};
    assign w_issue      = (w_avail_eff != '0) && (w_occ < 3'd4);
    assign w_count_next = r_count + {{ADDR_WIDTH{1'b0}}, w_push} - {{ADDR_WIDTH{1'b0}}, w_pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csb0  <= 1'b1;
            r_addr0 <= '0;
            r_din0  <= '0;
            r_wptr  <= '0;
        end else begin
            r_csb0 <= !w_push;
            if (w_push) begin
                r_addr0 <= r_wptr;
                r_din0  <= in_data;
                r_wptr  <= r_wptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csb1  <= 1'b1;
            r_addr1 <= '0;
            r_rptr  <= '0;
            r_avail <= '0;
            r_if0   <= 1'b0;
            r_if1   <= 1'b0;
        end else begin
            r_csb1  <= !w_issue;
            r_avail <= w_avail_eff - {{ADDR_WIDTH{1'b0}}, w_issue};
            r_if0   <= w_issue;
            r_if1   <= r_if0;
            if (w_issue) begin
                r_addr1 <= r_rptr;
                r_rptr  <= r_rptr + 1'b1;
            end
        end
    end

    // r_if1 marks the edge after the macro sampled the read: the only edge mem_dout1 is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_buf_cnt <= '0;
        end else begin
            r_buf_cnt <= r_buf_cnt + {2'b00, r_if1} - {2'b00, w_pop};
            if (r_if1) r_tail <= r_tail + 1'b1;
            if (w_pop) r_head <= r_head + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_buf
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_buf[gi] <= '0;
                else if (r_if1 && (r_tail == 2'(gi)))
                    r_buf[gi] <= mem_dout1;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_count <= '0;
        else     r_count <= w_count_next;
    end

`ifdef SRAM_FIFO_PEAK_EN
    logic [ADDR_WIDTH:0] r_peak;
    assign peak = r_peak;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_peak <= '0;
        else if (w_count_next > r_peak)
            r_peak <= w_count_next;
    end
`endif

endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

Single-clock FIFO controller that turns one `sram_0rw1r1w_32_1024_freepdk45` macro (1 write port, 1 read port, inputs registered on posedge, array access on negedge) into a valid/ready streaming FIFO of `RAM_DEPTH` words. It owns the write and read pointers and the occupancy count. It sequences the macro so that no address is read and written on the same negedge. A 4-entry output buffer absorbs the macro's read latency, so the FIFO sustains one push and one pop per cycle.

## Interface
- `DATA_WIDTH`, 32, word width; must match the macro.
- `ADDR_WIDTH`, 10, macro address width.
- `RAM_DEPTH`, `1 << ADDR_WIDTH`, FIFO capacity in words.
- `clk`  in  1  single clock. The macro's `clk0` and `clk1` are both tied to `clk` at the top level.
- `rst`  in  1  reset; **asynchronous, active-high**.
- `in_valid`  in  1  push request.
- `in_ready`  out  1  push accept.
- `in_data`  in  DATA_WIDTH  push word.
- `out_valid`  out  1  head word available.
- `out_ready`  in  1  pop accept.
- `out_data`  out  DATA_WIDTH  head word.
- `count`  out  ADDR_WIDTH+1  words accepted and not yet popped, range 0..RAM_DEPTH.
- `mem_csb0`  out  1  macro write chip select, active low.
- `mem_addr0`  out  ADDR_WIDTH  macro write address.
- `mem_din0`  out  DATA_WIDTH  macro write data.
- `mem_csb1`  out  1  macro read chip select, active low.
- `mem_addr1`  out  ADDR_WIDTH  macro read address.
- `mem_dout1`  in  DATA_WIDTH  macro read data.

## Operation
- **Push.** A push is accepted on a posedge where `in_valid && in_ready`.
  - `in_ready = !rst && (count < RAM_DEPTH)`.
  - On the accepting edge: `mem_csb0` goes 0, `mem_addr0` takes `wptr`, `mem_din0` takes `in_data` (all registered), and `wptr` increments modulo RAM_DEPTH.
  - `mem_csb0` returns to 1 on the next edge unless another push is accepted.
- **Avail counter.** `avail` counts words resident in the macro and not yet read-issued.
  - It increments one edge after push acceptance, i.e. on the edge where the macro samples the write.
  - This guarantees a read of that address is sampled no earlier than the following edge.
- **Read issue.** A read is issued on a posedge when `avail > 0` and `buffered + inflight < 4`, evaluated before this edge's pop.
  - On issue: `mem_csb1` goes 0, `mem_addr1` takes `rptr`, `rptr` increments modulo RAM_DEPTH, `avail` decrements.
  - On any edge with no issue, `mem_csb1` is 1.
- **Inflight pipeline.** A 2-stage valid shift register tracks inflight reads: issue edge, then macro sample edge.
  - `mem_dout1` is captured into the output buffer on the edge after the macro samples the read, i.e. 2 edges after issue.
  - It is never captured at any other time, because the macro drives X after hold.
- **Output buffer.** 4-entry circular buffer.
  - `out_valid = buffered > 0`; `out_data` is the buffer head.
  - A pop on `out_valid && out_ready` removes the head.
  - A capture and a pop on the same edge are both applied.
- **Count.** `count` increments on push, decrements on pop, and is unchanged on a simultaneous push and pop.
  - Because `count` includes inflight and buffered words, a write can never target a slot that is pending read. The full capacity of RAM_DEPTH words is usable.
- **Wrap.** Pointers wrap from RAM_DEPTH-1 to 0 with no special handling.

## Timing
- **Reset values:** `in_ready`=0 while `rst`, then 1. `out_valid`=0, `out_data`=0, `count`=0, `mem_csb0`=1, `mem_csb1`=1, addresses=0, `mem_din0`=0.
  - Pointers, `avail`, the inflight pipeline and the buffer all clear.
- **Latency:** a push accepted at edge k gives `out_valid`=1 after edge k+3 when the FIFO was empty.
- **Throughput:** 1 push and 1 pop per cycle sustained, with no bubbles once the buffer holds 2 or more words.
- **Full:** at `count`=RAM_DEPTH, `in_ready`=0. A pop on that edge lets `in_ready` rise after the edge; there is no same-cycle pass-through.
- **Empty:** `out_valid`=0. A push while empty is never forwarded combinationally.
- **Reset mid-operation:** chip selects deassert asynchronously. Read data from a read issued before reset is discarded. Macro contents are not cleared but are treated as invalid.

## Configuration
- `SRAM_FIFO_PEAK_EN`
  - **Defined:** adds output `peak` (width ADDR_WIDTH+1). It holds the maximum `count` reached since reset, updates on the same edge as `count`, and resets to 0.
  - **Undefined:** the port and its register are absent. All other behaviour is identical.

## Test plan
- **Single word:** after reset, push `0xDEADBEEF` at edge 1 -> `out_valid` rises after edge 4 with `out_data`=`0xDEADBEEF`; `count`=1 until popped.
- **Streaming:** push 0..2047 continuously with `out_ready`=1 -> output is in order 0..2047, with no gap after the first word, no X on `out_data`, and pointers wrapping twice.
- **Fill:** with `out_ready`=0, push 1030 words -> exactly 1024 accepted, `in_ready`=0 at `count`=1024. Draining then returns 0..1023 in order.
- **Full boundary:** at full, one pop plus `in_valid` held -> the push is accepted on the edge after the pop, `count` returns to 1024, and no write address matches the in-flight read address on the same edge.
- **Random backpressure:** random `in_valid`/`out_ready` at 50% for 10k cycles -> output matches a scoreboard, `count` equals scoreboard depth every cycle, and the buffer never exceeds 4.
- **Reset:** assert `rst` with 5 words stored and a read in flight -> `count`=0 and `out_valid`=0 immediately. After release, stale data never appears, and a fresh push `0x1` is the first output.
